// File: rtl/audio_stream_fifo_if.sv
// Handshake bundle between playback logic, the sample FIFO and the codec L/R sinks.
// slave is the FIFO's view; master is the view of whatever drives the playback side and codec READYs.
interface audio_stream_fifo_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              L_READY;
    logic              R_READY;
    logic [DATA_W-1:0] L_DATA;
    logic [DATA_W-1:0] R_DATA;
    logic              L_VALID;
    logic              R_VALID;

    modport master (
        output in_data, in_valid, flush, L_READY, R_READY,
        input  in_ready, L_DATA, R_DATA, L_VALID, R_VALID
    );

    modport slave (
        input  in_data, in_valid, flush, L_READY, R_READY,
        output in_ready, L_DATA, R_DATA, L_VALID, R_VALID
    );
endinterface

// File: rtl/audio_stream_fifo.sv
// Mono sample FIFO feeding independent L/R codec sinks; AUDIO_MUTE_EN adds a mute input zeroing output data.
// Latency: push into empty FIFO is presented one cycle later; back-to-back one sample per cycle when both READY.
// Backpressure: in_ready registered !full; a head pops only once both channels have taken it.
module audio_stream_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
`ifdef AUDIO_MUTE_EN
    input  logic                   mute,
`endif
    audio_stream_fifo_if.slave     bus,
    output logic [AW:0]            level,
    output logic [15:0]            underrun_count
);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       rd_ptr_inc;
    logic [AW:0]       wr_nxt;
    logic [AW:0]       rd_nxt;
    logic              empty;
    logic              full_nxt;

    logic              in_ready_q;
    logic              head_valid;
    logic              l_sent;
    logic              r_sent;
    logic              primed;
    logic [DATA_W-1:0] out_dat;

    logic              push;
    logic              pop;
    logic              l_vld;
    logic              r_vld;
    logic              l_fire;
    logic              r_fire;
    logic              load;
    logic              hv_nxt;
    logic [DATA_W-1:0] head_nxt;

    assign empty      = (wr_ptr == rd_ptr);
    assign level      = wr_ptr - rd_ptr;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    assign push   = bus.in_valid && in_ready_q;
    assign l_vld  = head_valid && !l_sent;
    assign r_vld  = head_valid && !r_sent;
    assign l_fire = l_vld && bus.L_READY;
    assign r_fire = r_vld && bus.R_READY;
    // Pop once each channel has either taken the head earlier or is taking it now.
    assign pop    = head_valid && (l_sent || l_fire) && (r_sent || r_fire);

    assign bus.in_ready = in_ready_q;
    assign bus.L_VALID  = l_vld;
    assign bus.R_VALID  = r_vld;
    assign bus.L_DATA   = out_dat;
    assign bus.R_DATA   = out_dat;

    // Pointer next-state drives the registered in_ready so it never lags a fill.
    always_comb begin
        wr_nxt = wr_ptr;
        rd_nxt = rd_ptr;
        if (bus.flush) begin
            wr_nxt = '0;
            rd_nxt = '0;
        end else begin
            if (push) wr_nxt = wr_ptr + 1'b1;
            if (pop)  rd_nxt = rd_ptr_inc;
        end
        full_nxt = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end

    // Output register refill: next stored entry, or the sample arriving this very cycle.
    always_comb begin
        load     = 1'b0;
        hv_nxt   = head_valid;
        head_nxt = mem[rd_ptr[AW-1:0]];
        if (pop) begin
            if (rd_ptr_inc != wr_ptr) begin
                load     = 1'b1;
                hv_nxt   = 1'b1;
                head_nxt = mem[rd_ptr_inc[AW-1:0]];
            end else if (push) begin
                load     = 1'b1;
                hv_nxt   = 1'b1;
                head_nxt = bus.in_data;
            end else begin
                hv_nxt   = 1'b0;
            end
        end else if (!head_valid && !empty) begin
            load   = 1'b1;
            hv_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !bus.flush) begin
            mem[wr_ptr[AW-1:0]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            in_ready_q <= 1'b0;
            head_valid <= 1'b0;
            l_sent     <= 1'b0;
            r_sent     <= 1'b0;
            primed     <= 1'b0;
            out_dat    <= '0;
        end else begin
            wr_ptr     <= wr_nxt;
            rd_ptr     <= rd_nxt;
            in_ready_q <= !full_nxt;
            if (bus.flush) begin
                head_valid <= 1'b0;
                l_sent     <= 1'b0;
                r_sent     <= 1'b0;
                primed     <= 1'b0;
            end else begin
                head_valid <= hv_nxt;
                l_sent     <= pop ? 1'b0 : (l_sent || l_fire);
                r_sent     <= pop ? 1'b0 : (r_sent || r_fire);
                if (push) primed <= 1'b1;
                if (load) begin
`ifdef AUDIO_MUTE_EN
                    out_dat <= mute ? '0 : head_nxt;
`else
                    out_dat <= head_nxt;
`endif
                end
            end
        end
    end

    // Underrun history survives flush so software can still read it afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_count <= '0;
        end else if (primed && empty && (bus.L_READY || bus.R_READY)
                     && (underrun_count != 16'hFFFF)) begin
            underrun_count <= underrun_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_audio_stream_fifo.sv
// Directed bench for audio_stream_fifo: reset, single sample, skew, full, underrun, flush, optional mute.
module tb_audio_stream_fifo;

    logic        clk;
    logic        reset_n;
    logic [6:0]  level;
    logic [15:0] underrun_count;
`ifdef AUDIO_MUTE_EN
    logic        mute;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] lq[$];
    logic [15:0] rq[$];

    audio_stream_fifo_if #(.DATA_W(16)) bus ();

    audio_stream_fifo #(.DATA_W(16), .DEPTH(64)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
`ifdef AUDIO_MUTE_EN
        .mute           (mute),
`endif
        .bus            (bus.slave),
        .level          (level),
        .underrun_count (underrun_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (bus.L_VALID && bus.L_READY) lq.push_back(bus.L_DATA);
            if (bus.R_VALID && bus.R_READY) rq.push_back(bus.R_DATA);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset_n      = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.flush    = 1'b0;
        bus.L_READY  = 1'b0;
        bus.R_READY  = 1'b0;
`ifdef AUDIO_MUTE_EN
        mute = 1'b0;
`endif
        #2;
        lq.delete();
        rq.delete();
        chk("rst_in_ready", 32'(bus.in_ready), 32'h0);
        chk("rst_l_valid", 32'(bus.L_VALID), 32'h0);
        chk("rst_r_valid", 32'(bus.R_VALID), 32'h0);
        chk("rst_l_data", 32'(bus.L_DATA), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_underrun", 32'(underrun_count), 32'h0);
        step();
        step();
        reset_n = 1'b1;
        chk("rst_in_ready_held", 32'(bus.in_ready), 32'h0);
        step();
        chk("rst_in_ready_rise", 32'(bus.in_ready), 32'h1);
    endtask

    initial begin
        reset_n = 1'b0;

        // Single sample with both sinks ready
        do_reset();
        bus.in_data  = 16'h1234;
        bus.in_valid = 1'b1;
        bus.L_READY  = 1'b1;
        bus.R_READY  = 1'b1;
        step();
        bus.in_valid = 1'b0;
        chk("single_level_after_push", 32'(level), 32'h1);
        chk("single_lvalid_early", 32'(bus.L_VALID), 32'h0);
        step();
        chk("single_lvalid", 32'(bus.L_VALID), 32'h1);
        chk("single_rvalid", 32'(bus.R_VALID), 32'h1);
        chk("single_ldata", 32'(bus.L_DATA), 32'h1234);
        chk("single_rdata", 32'(bus.R_DATA), 32'h1234);
        step();
        chk("single_level_after_pop", 32'(level), 32'h0);
        chk("single_lvalid_after_pop", 32'(bus.L_VALID), 32'h0);
        chk("single_lq_size", 32'(lq.size()), 32'h1);

        // Skewed channels: R held off for five cycles
        do_reset();
        bus.L_READY  = 1'b1;
        bus.R_READY  = 1'b0;
        bus.in_data  = 16'hAAAA;
        bus.in_valid = 1'b1;
        step();
        bus.in_data  = 16'hBBBB;
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        chk("skew_lq_size", 32'(lq.size()), 32'h1);
        chk("skew_lq0", 32'(lq[0]), 32'hAAAA);
        chk("skew_rq_size", 32'(rq.size()), 32'h0);
        chk("skew_level", 32'(level), 32'h2);
        chk("skew_lvalid", 32'(bus.L_VALID), 32'h0);
        chk("skew_rvalid", 32'(bus.R_VALID), 32'h1);
        chk("skew_underrun", 32'(underrun_count), 32'h0);
        bus.R_READY = 1'b1;
        step();
        step();
        step();
        chk("skew_lq_final", 32'(lq.size()), 32'h2);
        chk("skew_rq_final", 32'(rq.size()), 32'h2);
        chk("skew_lq1", 32'(lq[1]), 32'hBBBB);
        chk("skew_rq0", 32'(rq[0]), 32'hAAAA);
        chk("skew_rq1", 32'(rq[1]), 32'hBBBB);
        chk("skew_level_final", 32'(level), 32'h0);

        // Fill to 64 with sinks stalled, then drain
        do_reset();
        for (int i = 0; i < 64; i++) begin
            bus.in_data  = 16'h0100 + 16'(i);
            bus.in_valid = 1'b1;
            step();
        end
        chk("full_level", 32'(level), 32'd64);
        chk("full_in_ready", 32'(bus.in_ready), 32'h0);
        bus.in_data = 16'hDEAD;
        step();
        step();
        step();
        chk("full_level_hold", 32'(level), 32'd64);
        bus.in_valid = 1'b0;
        bus.L_READY  = 1'b1;
        bus.R_READY  = 1'b1;
        repeat (70) step();
        chk("full_drain_level", 32'(level), 32'h0);
        chk("full_lq_size", 32'(lq.size()), 32'd64);
        chk("full_rq_size", 32'(rq.size()), 32'd64);
        for (int i = 0; i < 64; i++) begin
            chk("full_drain_l", 32'(lq[i]), 32'h0100 + 32'(i));
            chk("full_drain_r", 32'(rq[i]), 32'h0100 + 32'(i));
        end

        // Underrun counting and saturation
        do_reset();
        bus.in_data  = 16'h0055;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        bus.L_READY = 1'b1;
        bus.R_READY = 1'b1;
        step();
        chk("under_level", 32'(level), 32'h0);
        chk("under_zero", 32'(underrun_count), 32'h0);
        repeat (10) step();
        bus.L_READY = 1'b0;
        bus.R_READY = 1'b0;
        chk("under_ten", 32'(underrun_count), 32'd10);
        step();
        chk("under_idle_hold", 32'(underrun_count), 32'd10);
        bus.L_READY = 1'b1;
        repeat (70000) step();
        chk("under_saturate", 32'(underrun_count), 32'hFFFF);

        // Flush with a concurrent push
        do_reset();
        for (int i = 0; i < 5; i++) begin
            bus.in_data  = 16'h0500 + 16'(i);
            bus.in_valid = 1'b1;
            step();
        end
        chk("flush_level_pre", 32'(level), 32'd5);
        bus.in_data = 16'h0BAD;
        bus.flush   = 1'b1;
        step();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("flush_level", 32'(level), 32'h0);
        chk("flush_lvalid", 32'(bus.L_VALID), 32'h0);
        chk("flush_rvalid", 32'(bus.R_VALID), 32'h0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'h1);
        bus.L_READY  = 1'b1;
        bus.R_READY  = 1'b1;
        bus.in_data  = 16'h0777;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("flush_next_lvalid", 32'(bus.L_VALID), 32'h1);
        chk("flush_next_ldata", 32'(bus.L_DATA), 32'h0777);
        step();
        chk("flush_next_level", 32'(level), 32'h0);
        chk("flush_lq_size", 32'(lq.size()), 32'h1);
        chk("flush_lq0", 32'(lq[0]), 32'h0777);
        chk("flush_rq0", 32'(rq[0]), 32'h0777);

`ifdef AUDIO_MUTE_EN
        // Muted samples drain as zeros, unmuted sample keeps its value
        do_reset();
        mute        = 1'b1;
        bus.L_READY = 1'b1;
        bus.R_READY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data  = 16'h00A1 + 16'(i);
            bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        repeat (5) step();
        chk("mute_lq_size", 32'(lq.size()), 32'd3);
        chk("mute_rq_size", 32'(rq.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("mute_l_zero", 32'(lq[i]), 32'h0);
            chk("mute_r_zero", 32'(rq[i]), 32'h0);
        end
        chk("mute_level", 32'(level), 32'h0);
        mute         = 1'b0;
        bus.in_data  = 16'h4242;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        repeat (3) step();
        chk("unmute_lq_size", 32'(lq.size()), 32'd4);
        chk("unmute_l", 32'(lq[3]), 32'h4242);
        chk("unmute_r", 32'(rq[3]), 32'h4242);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
